// File: rtl/exu_lsu_pipe.sv
// EXU load/store unit: issues word-aligned memory requests with lane-shifted
// data and strobes. It tracks up to OUTSTANDING in-order requests, aligns
// returning load data into the GPR file, and traps illegal or misaligned ops.
module exu_lsu_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned GPR_AW      = 5,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_vld,
  output logic                iss_rdy,
  input  logic                iss_st,
  input  logic [2:0]          iss_funct3,
  input  logic [GPR_AW-1:0]   iss_rd,
  input  logic [XLEN-1:0]     iss_base,
  input  logic [XLEN-1:0]     iss_offset,
  input  logic [XLEN-1:0]     iss_wdata,
  output logic                req_vld,
  input  logic                req_rdy,
  output logic [XLEN-1:0]     req_addr,
  output logic                req_st,
  output logic [XLEN-1:0]     req_data,
  output logic [XLEN/8-1:0]   req_strobe,
  input  logic                rsp_vld,
  output logic                rsp_rdy,
  input  logic [XLEN-1:0]     rsp_data,
  output logic                gpr_wen,
  output logic [GPR_AW-1:0]   gpr_waddr,
  output logic [XLEN-1:0]     gpr_wdata,
  output logic                exc_vld,
  output logic [1:0]          exc_cause,
  output logic [XLEN-1:0]     exc_addr,
  output logic                idle
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  logic [XLEN-1:0] ea;
  logic [OB-1:0]   off;
  logic [1:0]      sz;
  logic            legal;
  logic [2:0]      amask;
  logic            misal;
  logic            trap;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ent_st_q  [OUTSTANDING];
  logic [2:0]      ent_f3_q  [OUTSTANDING];
  logic [GPR_AW-1:0] ent_rd_q [OUTSTANDING];
  logic [OB-1:0]   ent_off_q [OUTSTANDING];

  logic            exc_vld_q;
  logic [1:0]      exc_cause_q;
  logic [XLEN-1:0] exc_addr_q;

  logic            h_st;
  logic [2:0]      h_f3;
  logic [GPR_AW-1:0] h_rd;
  logic [OB-1:0]   h_off;
  logic [XLEN-1:0] shifted;
  logic            sbit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ea  = iss_base + iss_offset;
  assign off = ea[OB-1:0];
  assign sz  = iss_funct3[1:0];

  // Legality of funct3 and natural-alignment check for the issued operation
  always_comb begin
    legal = 1'b0;
    amask = 3'd0;
    case (iss_funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd3:             legal = (XLEN == 64);
      3'd4, 3'd5:       legal = ~iss_st;
      3'd6:             legal = ~iss_st && (XLEN == 64);
      default:          legal = 1'b0;
    endcase
    case (sz)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
  end

  assign misal = |(off & amask[OB-1:0]);
  assign trap  = ~legal | misal;
  assign full  = (cnt_q == CW'(OUTSTANDING));
  assign empty = (cnt_q == '0);

  assign iss_rdy  = trap | (~full & req_rdy);
  assign req_vld  = iss_vld & ~full & ~trap;
  assign req_st   = iss_st;
  assign req_addr = {ea[XLEN-1:OB], {OB{1'b0}}};
  assign req_data = iss_wdata << {off, 3'b000};
  assign push     = req_vld & req_rdy;

  assign rsp_rdy  = ~empty;
  assign pop      = rsp_vld & ~empty;
  assign idle     = empty;

  // Byte-enable window [off, off+size) over the word lanes
  always_comb begin
    req_strobe = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      req_strobe[i] = (i >= 32'(off)) && (i < 32'(off) + (32'd1 << sz));
    end
  end

  // Occupancy and ring pointers; push and pop together leave count unchanged
  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, count and exception registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      exc_vld_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      exc_vld_q <= iss_vld & trap;
      if (iss_vld & trap) begin
        exc_cause_q <= legal ? 2'b01 : 2'b10;
        exc_addr_q  <= ea;
      end
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) begin
      ent_st_q[wptr_q]  <= iss_st;
      ent_f3_q[wptr_q]  <= iss_funct3;
      ent_rd_q[wptr_q]  <= iss_rd;
      ent_off_q[wptr_q] <= off;
    end
  end

  assign h_st  = ent_st_q[rptr_q];
  assign h_f3  = ent_f3_q[rptr_q];
  assign h_rd  = ent_rd_q[rptr_q];
  assign h_off = ent_off_q[rptr_q];

  assign shifted   = rsp_data >> {h_off, 3'b000};
  assign gpr_wen   = pop & ~h_st & (h_rd != '0);
  assign gpr_waddr = h_rd;

  // Truncate to access size, then sign-extend unless funct3 marks unsigned
  always_comb begin
    gpr_wdata = '0;
    case (h_f3[1:0])
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[XLEN-1];
    endcase
    for (int unsigned i = 0; i < XLEN; i++) begin
      gpr_wdata[i] = (i < (32'd8 << h_f3[1:0])) ? shifted[i] : (~h_f3[2] & sbit);
    end
  end

  assign exc_vld   = exc_vld_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: doc/exu_lsu_pipe.md
Name: exu_lsu_pipe

Overview:
Parametrised load/store unit for the EXU, the successor to the single-outstanding ldst handler. It accepts decoded load/store operations from issue and drives a word-aligned memory request channel with lane-shifted data and strobes. It tracks up to OUTSTANDING in-order requests, aligns load data, and writes the GPR file on response. Misaligned accesses and illegal funct3 values are trapped without issuing a request.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
GPR_AW, 5, GPR address width.
OUTSTANDING, 2, maximum in-flight requests; legal range 1..8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
iss_vld  in  1  operation valid
iss_rdy  out  1  operation accepted when high together with iss_vld
iss_st  in  1  1 = store, 0 = load
iss_funct3  in  3  RV load/store funct3
iss_rd  in  GPR_AW  load destination register
iss_base  in  XLEN  rs1 value
iss_offset  in  XLEN  sign-extended I/S immediate
iss_wdata  in  XLEN  rs2 value (stores)
req_vld  out  1  memory request valid
req_rdy  in  1  memory ready
req_addr  out  XLEN  address, low log2(XLEN/8) bits forced to 0
req_st  out  1  store flag
req_data  out  XLEN  lane-shifted store data
req_strobe  out  XLEN/8  byte enables
rsp_vld  in  1  response valid
rsp_rdy  out  1  response accepted
rsp_data  in  XLEN  full-word read data
gpr_wen  out  1  GPR write enable
gpr_waddr  out  GPR_AW  GPR write address
gpr_wdata  out  XLEN  aligned, extended load result
exc_vld  out  1  one-cycle exception pulse
exc_cause  out  2  01 = misaligned, 10 = illegal funct3
exc_addr  out  XLEN  faulting effective address
idle  out  1  no requests outstanding

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: queue empty, idle=1, exc_vld=0, exc_cause=0, exc_addr=0. All other outputs are combinational: req_vld=0, rsp_rdy=0, gpr_wen=0.
- Effective address: ea = iss_base + iss_offset, computed modulo 2^XLEN. off = ea[log2(XLEN/8)-1:0].
- Legal funct3:
  - Loads: 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU). When XLEN=64, 3 (LD) and 6 (LWU) are also legal.
  - Stores: 0 (SB), 1 (SH), 2 (SW). When XLEN=64, 3 (SD) is also legal.
  - Any other value is illegal.
- Access size: 2^funct3[1:0] bytes.
- Misaligned: off is not a multiple of the access size.
- Trap path (illegal or misaligned operation):
  - iss_rdy=1 and req_vld=0; no request is issued.
  - On the next cycle, exc_vld=1 for exactly one cycle, with exc_cause and exc_addr=ea registered.
  - If an operation is both illegal and misaligned, illegal takes priority.
- Normal path, zero-latency pass-through:
  - req_vld = iss_vld & ~full.
  - iss_rdy = ~full & req_rdy.
  - req_st = iss_st.
  - req_data = iss_wdata << (8*off).
  - req_strobe = ((1<<size)-1) << off.
  - For loads, req_strobe is driven the same way and req_data is don't-care.
- Request handshake pushes {st, funct3, rd, off} into a FIFO of OUTSTANDING entries.
- No full-bypass: when full, iss_rdy=0 even if a response pops in the same cycle. req_vld must not depend on req_rdy.
- Responses:
  - Returned in order. rsp_rdy = ~empty; a response arriving while empty is not accepted.
  - On rsp handshake the head entry pops.
  - Loads: gpr_wen=1 in the same cycle, gpr_waddr = entry rd. gpr_wen is suppressed when rd==0.
  - Load data: gpr_wdata = (rsp_data >> 8*off), truncated to the access size, then sign-extended (LB/LH/LW on XLEN=64) or zero-extended (LBU/LHU/LWU). LW on XLEN=32 and LD pass through unextended.
  - Stores: pop with gpr_wen=0.
- Simultaneous push and pop in one cycle: occupancy is unchanged; the pointers wrap modulo OUTSTANDING.
- idle = empty.
- Reset mid-operation drops all in-flight entries. Any responses that arrive later are never accepted because rsp_rdy=0.

Test Plan:
- Basic load: XLEN=32, LW with base=0x1000, offset=4; req_rdy=1 -> req_addr=0x1004, strobe=4'b1111, st=0. Then rsp_data=0xDEADBEEF -> gpr_wen=1, wdata=0xDEADBEEF, rd as issued.
- Sub-word load: LB at ea=0x1003, rsp_data=0x80FFFFFF -> req_addr=0x1000, strobe=4'b1000, wdata=0xFFFFFF80. Same access as LBU -> wdata=0x00000080.
- Sub-word store: SH at ea=0x2002, wdata=0x1234ABCD -> req_addr=0x2000, strobe=4'b1100, req_data=0xABCD0000. The store response produces no gpr_wen.
- Traps: LW at ea=0x1002 -> no req_vld, iss_rdy=1, exc_vld pulse with cause=01 and addr=0x1002. funct3=7 -> cause=10.
- Backpressure: OUTSTANDING=2 with 3 back-to-back loads to rd=1,2,3 and rsp_vld held low -> third load sees iss_rdy=0 and idle=0. Two responses then write rd 1 then 2, after which the third load issues.
- XLEN=64: LWU at ea=0x...04, rsp_data=0x80000000_00000000 -> strobe=8'hF0, wdata=0x0000000080000000. Also check rd=0 load gives gpr_wen=0, and reset while 2 loads are outstanding gives idle=1 and rsp_rdy=0.
